// File: rtl/isa_camac_read_port.sv
// ISA I/O read responder: fetches a 24-bit CAMAC word via req/ack and
// returns it byte-wise on the ISA bus with IOCHRDY wait-state control.
module isa_camac_read_port #(
    parameter logic [9:0]  BASE_ADDR   = 10'h300,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  addr,
    input  logic        aen,
    input  logic        ior_n,
    input  logic [23:0] camac_r,
    input  logic        camac_q,
    input  logic        camac_x,
    input  logic        camac_read_ack,
    output logic        camac_read_req,
    output logic [7:0]  isa_data,
    output logic        isa_oe_n,
    output logic        iochrdy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRIVE,
        RELEASE
    } state_t;

    localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

    state_t      state_q, state_d;
    logic        ior_s1_q, ior_s2_q, ior_s3_q;
    logic [1:0]  off_q, off_d;
    logic        pend_q, pend_d;
    logic        abort_q, abort_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [23:0] r_q, r_d;
    logic        q_q, q_d;
    logic        x_q, x_d;
    logic        to_q, to_d;

    logic        ior_fall;
    logic        hit;
    logic        abort_now;
    logic [7:0]  cnt_inc;

    assign ior_fall  = ior_s3_q & ~ior_s2_q;
    assign hit       = ~aen && (addr[9:2] == BASE_ADDR[9:2]);
    assign abort_now = abort_q | ior_s2_q;
    assign cnt_inc   = cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ior_s1_q <= 1'b1;
            ior_s2_q <= 1'b1;
            ior_s3_q <= 1'b1;
        end else begin
            ior_s1_q <= ior_n;
            ior_s2_q <= ior_s1_q;
            ior_s3_q <= ior_s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            off_q   <= 2'd0;
            pend_q  <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= 8'd0;
            r_q     <= 24'd0;
            q_q     <= 1'b0;
            x_q     <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            pend_q  <= pend_d;
            abort_q <= abort_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            x_q     <= x_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        pend_d  = pend_q;
        abort_d = abort_q;
        cnt_d   = 8'd0;
        r_d     = r_q;
        q_d     = q_q;
        x_d     = x_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                // Offset-0 read waits here while the sequencer still shows ack
                if (pend_q) begin
                    if (ior_s2_q) abort_d = 1'b1;
                    if (!camac_read_ack) begin
                        pend_d  = 1'b0;
                        state_d = REQ;
                    end
                end else if (ior_fall && hit) begin
                    off_d   = addr[1:0];
                    abort_d = 1'b0;
                    if (addr[1:0] == 2'd0) begin
                        if (camac_read_ack) pend_d = 1'b1;
                        else state_d = REQ;
                    end else begin
                        state_d = DRIVE;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                if (ior_s2_q) abort_d = 1'b1;
                if (camac_read_ack) begin
                    r_d     = camac_r;
                    q_d     = camac_q;
                    x_d     = camac_x;
                    to_d    = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = abort_now ? IDLE : DRIVE;
                end else if (cnt_inc == TMO) begin
                    r_d     = 24'hFFFFFF;
                    q_d     = 1'b0;
                    x_d     = 1'b0;
                    to_d    = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = abort_now ? IDLE : DRIVE;
                end
            end
            DRIVE: begin
                if (ior_s2_q) state_d = RELEASE;
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign camac_read_req = (state_q == REQ);
    assign iochrdy        = ~((state_q == REQ) | pend_q);
    assign isa_oe_n       = (state_q != DRIVE);

    // Mux only from registers that are frozen outside IDLE/REQ
    always_comb begin
        isa_data = 8'h00;
        unique case (off_q)
            2'd0: isa_data = r_q[7:0];
            2'd1: isa_data = r_q[15:8];
            2'd2: isa_data = r_q[23:16];
            2'd3: isa_data = {5'b0, to_q, x_q, q_q};
            default: isa_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_isa_camac_read_port.sv
// Directed bench for isa_camac_read_port with a CAMAC sequencer model
// and a queue of expected ISA read bytes.
module tb_isa_camac_read_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  addr;
    logic        aen;
    logic        ior_n;
    logic [23:0] camac_r;
    logic        camac_q;
    logic        camac_x;
    logic        camac_read_ack;
    logic        camac_read_req;
    logic [7:0]  isa_data;
    logic        isa_oe_n;
    logic        iochrdy;

    logic        ack_model = 1'b0;
    logic        ack_force = 1'b0;
    bit          seq_en = 1'b1;
    int          seq_dly = 2;
    int          dly_cnt = 0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  sb[$];

    assign camac_read_ack = ack_model | ack_force;

    isa_camac_read_port #(
        .BASE_ADDR(10'h300),
        .ACK_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .addr(addr),
        .aen(aen),
        .ior_n(ior_n),
        .camac_r(camac_r),
        .camac_q(camac_q),
        .camac_x(camac_x),
        .camac_read_ack(camac_read_ack),
        .camac_read_req(camac_read_req),
        .isa_data(isa_data),
        .isa_oe_n(isa_oe_n),
        .iochrdy(iochrdy)
    );

    always #5 clk = ~clk;

    // Sequencer: one-cycle ack pulse seq_dly+1 cycles after req rises
    always @(posedge clk) begin
        if (seq_en && camac_read_req && !ack_model) begin
            if (dly_cnt >= seq_dly) begin
                ack_model <= 1'b1;
                dly_cnt   <= 0;
            end else begin
                dly_cnt <= dly_cnt + 1;
            end
        end else begin
            ack_model <= 1'b0;
            dly_cnt   <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_read(input logic [9:0] a);
        addr  = a;
        aen   = 1'b0;
        ior_n = 1'b0;
    endtask

    task automatic finish_read(input string tag, input int exp_rc);
        int rc = 0;
        int bad = 0;
        logic [7:0] e;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (!isa_oe_n) break;
            if (camac_read_req) begin
                rc++;
                if (iochrdy) bad++;
            end
        end
        check({tag, "_oe"}, {31'd0, isa_oe_n}, 32'd0);
        e = sb.pop_front();
        check({tag, "_data"}, {24'd0, isa_data}, {24'd0, e});
        check({tag, "_rdy"}, {31'd0, iochrdy}, 32'd1);
        check({tag, "_reqcyc"}, rc, exp_rc);
        check({tag, "_rdylow"}, bad, 0);
        ior_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (isa_oe_n) break;
        end
        check({tag, "_oeoff"}, {31'd0, isa_oe_n}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_read(input string tag, input logic [9:0] a,
                           input logic [7:0] exp, input int exp_rc);
        sb.push_back(exp);
        start_read(a);
        finish_read(tag, exp_rc);
    endtask

    task automatic idle_probe(input string tag);
        repeat (10) @(negedge clk);
        check({tag, "_req"}, {31'd0, camac_read_req}, 32'd0);
        check({tag, "_oe"}, {31'd0, isa_oe_n}, 32'd1);
        check({tag, "_rdy"}, {31'd0, iochrdy}, 32'd1);
        ior_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int oe_low;
        rst_n   = 1'b0;
        addr    = 10'h000;
        aen     = 1'b1;
        ior_n   = 1'b1;
        camac_r = 24'h000000;
        camac_q = 1'b0;
        camac_x = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, camac_read_req}, 32'd0);
        check("rst_oe", {31'd0, isa_oe_n}, 32'd1);
        check("rst_rdy", {31'd0, iochrdy}, 32'd1);
        check("rst_data", {24'd0, isa_data}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        camac_r = 24'hA5C33C;
        camac_q = 1'b1;
        camac_x = 1'b1;
        seq_dly = 2;
        do_read("a_off0", 10'h300, 8'h3C, 4);
        camac_r = 24'h000000;
        do_read("a_off1", 10'h301, 8'hC3, 0);
        do_read("a_off2", 10'h302, 8'hA5, 0);
        do_read("a_off3", 10'h303, 8'h03, 0);

        camac_r = 24'h5A0F81;
        camac_q = 1'b0;
        camac_x = 1'b1;
        seq_dly = 0;
        do_read("min_off0", 10'h300, 8'h81, 2);
        do_read("min_off3", 10'h303, 8'h02, 0);

        seq_en = 1'b0;
        do_read("tmo_off0", 10'h300, 8'hFF, 255);
        do_read("tmo_off3", 10'h303, 8'h04, 0);
        do_read("tmo_off1", 10'h301, 8'hFF, 0);
        seq_en  = 1'b1;
        seq_dly = 1;
        camac_r = 24'h001122;
        camac_q = 1'b1;
        camac_x = 1'b0;
        do_read("clr_off0", 10'h300, 8'h22, 3);
        do_read("clr_off3", 10'h303, 8'h01, 0);

        camac_r   = 24'h77BEEF;
        seq_dly   = 2;
        ack_force = 1'b1;
        sb.push_back(8'hEF);
        start_read(10'h300);
        repeat (10) @(negedge clk);
        check("defer_req", {31'd0, camac_read_req}, 32'd0);
        check("defer_rdy", {31'd0, iochrdy}, 32'd0);
        ack_force = 1'b0;
        finish_read("defer_off0", 4);
        do_read("defer_off2", 10'h302, 8'h77, 0);

        camac_r = 24'h123456;
        camac_q = 1'b1;
        camac_x = 1'b1;
        start_read(10'h300);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (camac_read_req) break;
        end
        check("abort_reqseen", {31'd0, camac_read_req}, 32'd1);
        ior_n  = 1'b1;
        oe_low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!isa_oe_n) oe_low++;
        end
        check("abort_oelow", oe_low, 0);
        check("abort_req", {31'd0, camac_read_req}, 32'd0);
        check("abort_rdy", {31'd0, iochrdy}, 32'd1);
        camac_r = 24'h000000;
        do_read("abort_off1", 10'h301, 8'h34, 0);
        do_read("abort_off2", 10'h302, 8'h12, 0);
        do_read("abort_off3", 10'h303, 8'h03, 0);

        addr  = 10'h300;
        aen   = 1'b1;
        ior_n = 1'b0;
        idle_probe("aen");
        addr  = 10'h304;
        aen   = 1'b0;
        ior_n = 1'b0;
        idle_probe("nohit");

        seq_en = 1'b0;
        start_read(10'h300);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (camac_read_req) break;
        end
        check("mid_reqseen", {31'd0, camac_read_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_req", {31'd0, camac_read_req}, 32'd0);
        check("mid_oe", {31'd0, isa_oe_n}, 32'd1);
        check("mid_rdy", {31'd0, iochrdy}, 32'd1);
        ior_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        seq_en = 1'b1;
        repeat (3) @(negedge clk);
        do_read("mid_off2", 10'h302, 8'h00, 0);
        do_read("mid_off3", 10'h303, 8'h00, 0);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/isa_camac_read_port.md
# isa_camac_read_port

ISA-side read responder for the sm2201 interface board: it answers host I/O reads, fetches a 24-bit CAMAC read word through a request/acknowledge handshake with the CAMAC cycle sequencer, and returns it byte-wise on the 8-bit ISA data bus. It is the read-direction counterpart of the 74LS374-style write latch path (ISA to CAMAC). It holds IOCHRDY low while the CAMAC cycle is in flight and drives the ISA data buffer enable with active-low, 374-style output control.

## Interface
- BASE_ADDR, 10'h300: ISA I/O base; four consecutive ports decoded.
- ACK_TIMEOUT, 255: clk cycles to wait for camac_read_ack before abort (8-bit counter, 1..255).
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- addr  in  10  ISA SA[9:0]
- aen  in  1  ISA AEN; decode only when 0
- ior_n  in  1  ISA IOR#, asynchronous to clk; 2-FF synchronised internally
- camac_r  in  24  CAMAC R1..R24 read lines
- camac_q, camac_x  in  1  CAMAC Q and X responses
- camac_read_ack  in  1  sequencer: read cycle complete, camac_r valid
- camac_read_req  out  1  request CAMAC read cycle
- isa_data  out  8  byte for ISA D[7:0] buffer
- isa_oe_n  out  1  ISA data buffer enable, 0 = drive
- iochrdy  out  1  0 = hold ISA cycle

## Operation
- Decode hit: aen==0, addr[9:2]==BASE_ADDR[9:2]; offset = addr[1:0], latched at IOR falling edge (synchronised).
- Offset 0: start CAMAC read, return R[7:0]. Offset 1: R[15:8]; offset 2: R[23:16] from last capture, no CAMAC cycle. Offset 3: status {5'b0, timeout, X, Q}.
- States: IDLE, REQ, DRIVE, RELEASE.
- IDLE: on synced ior_n falling edge with hit: offset 0 -> REQ if camac_read_ack==0, else remain IDLE (request deferred, iochrdy=0) until ack low, then REQ. Offsets 1-3 -> DRIVE.
- REQ: camac_read_req=1, iochrdy=0, timeout counter increments. On ack==1: capture camac_r, Q, X; clear timeout flag; -> DRIVE. On counter==ACK_TIMEOUT: capture R=24'hFFFFFF, Q=0, X=0, set timeout flag; -> DRIVE.
- DRIVE: isa_oe_n=0, isa_data=selected byte, iochrdy=1; stay until synced ior_n==1 -> RELEASE.
- RELEASE: isa_oe_n=1 one cycle, -> IDLE.
- Host abort: ior_n rises during REQ -> complete handshake/timeout and capture, then go straight to IDLE, isa_oe_n never asserted.
- Captured R/Q/X/timeout persist until next offset-0 read.

## Timing
- Reset (async assert, sync-free deassert): state IDLE, camac_read_req=0, isa_oe_n=1, iochrdy=1, isa_data=8'h00, captures and timeout=0, counter=0.
- Reset mid-cycle: all outputs immediately return to reset values; in-flight capture discarded.
- ior_n edge detected 2 cycles after pin change (2-FF) plus 1 cycle edge compare; iochrdy low and camac_read_req high on the cycle REQ is entered.
- Capture on the clk edge where ack is sampled 1; camac_read_req drops the following cycle; isa_oe_n low and iochrdy high in that same cycle.
- Minimum offset-0 latency, edge-detect to isa_oe_n=0: 2 cycles with ack returning 1 cycle after req.
- isa_data stable whenever isa_oe_n=0; changes only in IDLE/REQ.
- Timeout: DRIVE entered exactly ACK_TIMEOUT cycles after REQ entry.
- Reads with aen=1 or no address hit: no state change, outputs untouched.

## Test plan
- Reset: rst_n low mid-REQ -> req=0, isa_oe_n=1, iochrdy=1 immediately; next offset-2 read returns 8'h00.
- Offset 0 read, camac_r=24'hA5C33C, Q=1, X=1, ack 3 cycles after req -> iochrdy low until capture, isa_data=8'h3C with isa_oe_n=0; offsets 1, 2, 3 then return 8'hC3, 8'hA5, 8'h03 without asserting req.
- No ack, ACK_TIMEOUT=255 -> DRIVE after 255 cycles, offset 0 returns 8'hFF, status 8'h04; next successful read clears status bit 2.
- ack stuck high at offset-0 IOR -> req stays 0, iochrdy 0 until ack drops, then normal REQ.
- Host abort: ior_n rises 1 cycle into REQ -> handshake completes, isa_oe_n stays 1, captured word readable via offset 1.
- aen=1 with addr=10'h300, and addr=10'h304 -> no req, isa_oe_n=1, iochrdy=1.
